// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch stage: opcodes, next-PC select codes,
// the canonical NOP and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_ALU = 2'b10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32 immediate decoder; the format is chosen by ir[6:0].
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'h0;
    case (ir[6:0])
      OP_I, OP_LOAD, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:               imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:              imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       imm = {ir[31:12], 12'h000};
      OP_JAL:                 imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch / PC stage: PC, PC0 and IR registers, next-PC selection,
// a one-shot request/valid handshake to instruction memory and IR field decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic        PC0_Write,
  input  logic        IR_Write,
  input  logic [1:0]  PC_s,
  input  logic [31:0] alu_res,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc0,
  output logic        busy,
  output logic        misalign
);

  import riscv_pkg::fetch_state_t;
  import riscv_pkg::ST_IDLE;
  import riscv_pkg::ST_WAIT;
  import riscv_pkg::PCS_SEQ;
  import riscv_pkg::PCS_BR;
  import riscv_pkg::PCS_ALU;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  pc0_reg, pc0_next;
  logic [31:0]  ir_reg, ir_next;
  logic [31:0]  addr_reg, addr_next;
  logic         req_reg, req_next;
  logic         mis_reg, mis_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      pc0_reg   <= RESET_PC;
      ir_reg    <= NOP_INSN;
      addr_reg  <= RESET_PC;
      req_reg   <= 1'b0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pc0_reg   <= pc0_next;
      ir_reg    <= ir_next;
      addr_reg  <= addr_next;
      req_reg   <= req_next;
      mis_reg   <= mis_next;
    end
  end

  // All strobes sample the pre-edge PC, so a combined fetch step fetches the
  // old PC, parks it in PC0 and advances PC in the same edge.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pc0_next   = pc0_reg;
    ir_next    = ir_reg;
    addr_next  = addr_reg;
    req_next   = 1'b0;
    mis_next   = mis_reg;
    case (state_reg)
      ST_IDLE: begin
        if (PC_Write) begin
          case (PC_s)
            PCS_SEQ: pc_next = pc_reg + 32'd4;
            PCS_BR:  pc_next = pc0_reg + imm;
            PCS_ALU: pc_next = alu_res & ~32'h1;
            default: pc_next = pc_reg;
          endcase
        end
        if (PC0_Write) begin
          pc0_next = pc_reg;
        end
        if (IR_Write) begin
          if (pc_reg[1:0] == 2'b00) begin
            req_next   = 1'b1;
            addr_next  = pc_reg;
            state_next = ST_WAIT;
          end else begin
            ir_next  = NOP_INSN;
            mis_next = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          ir_next    = imem_rdata;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  imm_gen u_imm_gen (
    .ir  (ir_reg),
    .imm (imm)
  );

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign ir        = ir_reg;
  assign opcode    = ir_reg[6:0];
  assign funct3    = ir_reg[14:12];
  assign funct7    = ir_reg[31:25];
  assign rs1       = ir_reg[19:15];
  assign rs2       = ir_reg[24:20];
  assign rd        = ir_reg[11:7];
  assign pc        = pc_reg;
  assign pc0       = pc0_reg;
  assign busy      = (state_reg == ST_WAIT);
  assign misalign  = mis_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed plus randomized checks of ifetch_unit against a transaction-level
// model of PC / PC0 / IR behaviour.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0, pc0_write = 1'b0, ir_write = 1'b0;
  logic [1:0]  pc_s = 2'b00;
  logic [31:0] alu_res = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic [31:0] ir, imm, pc, pc0;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        busy, misalign;

  int total = 0;
  int bad = 0;

  // reference state
  logic [31:0] m_pc, m_pc0, m_ir, m_addr;
  logic        m_mis;

  ifetch_unit dut (
    .clk(clk), .rst(rst),
    .PC_Write(pc_write), .PC0_Write(pc0_write), .IR_Write(ir_write), .PC_s(pc_s),
    .alu_res(alu_res),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .ir(ir), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .pc(pc), .pc0(pc0), .busy(busy), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imm_ref(input logic [31:0] w);
    logic signed [31:0] s;
    s = $signed(w);
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return 32'(s >>> 20);
      7'b0100011: return (32'(s >>> 20) & ~32'h1F) | 32'(w[11:7]);
      7'b1100011: return (32'(s >>> 31) & 32'hFFFF_F000) | (32'(w[7]) << 11)
                         | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
      7'b1101111: return (32'(s >>> 31) & 32'hFFF0_0000) | (w & 32'h000F_F000)
                         | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc0"}, pc0, m_pc0);
    chk({tag, ".ir"}, ir, m_ir);
    chk({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
    chk({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, ".imm"}, imm, imm_ref(m_ir));
    chk({tag, ".fields"}, {opcode, funct3, funct7, rs1, rs2, rd},
        32'({m_ir[6:0], m_ir[14:12], m_ir[31:25], m_ir[19:15], m_ir[24:20], m_ir[11:7]}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_pc = 32'h0; m_pc0 = 32'h0; m_ir = NOP; m_addr = 32'h0; m_mis = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_write = 1'b1; pc_s = 2'b10; alu_res = v;
    cyc();
    pc_write = 1'b0;
    m_pc = v & ~32'h1;
    chk("set_pc", pc, m_pc);
  endtask

  task automatic branch(input logic en);
    pc_write = en; pc_s = 2'b01;
    cyc();
    pc_write = 1'b0;
    if (en) m_pc = m_pc0 + imm_ref(m_ir);
    chk("branch.pc", pc, m_pc);
  endtask

  // Combined fetch step; memory answers on the lat-th busy cycle. Junk
  // PC_Write strobes are driven while busy and must be ignored.
  task automatic fetch(input logic [31:0] word, input int lat);
    logic [31:0] old_pc;
    int busy_cycles;
    old_pc = m_pc;
    pc_write = 1'b1; pc0_write = 1'b1; ir_write = 1'b1; pc_s = 2'b00;
    cyc();
    pc_write = 1'b0; pc0_write = 1'b0; ir_write = 1'b0;
    m_pc0 = old_pc;
    m_pc = old_pc + 32'd4;
    if (old_pc[1:0] != 2'b00) begin
      m_ir = NOP;
      m_mis = 1'b1;
      chk("fetch_mis.req", 32'(imem_req), 32'h0);
      chk("fetch_mis.addr", imem_addr, m_addr);
      chk_state("fetch_mis");
      cyc();
      chk("fetch_mis.req_later", 32'(imem_req), 32'h0);
    end else begin
      m_addr = old_pc;
      chk("fetch.req", 32'(imem_req), 32'h1);
      chk("fetch.addr", imem_addr, m_addr);
      busy_cycles = 0;
      for (int i = 1; i <= lat; i++) begin
        if (busy) busy_cycles++;
        pc_write = 1'($urandom_range(0, 1));
        pc0_write = 1'($urandom_range(0, 1));
        ir_write = 1'($urandom_range(0, 1));
        pc_s = 2'($urandom_range(0, 3));
        alu_res = $urandom;
        imem_valid = (i == lat);
        imem_rdata = (i == lat) ? word : $urandom;
        cyc();
        if (i < lat) chk("fetch.req_low", 32'(imem_req), 32'h0);
      end
      pc_write = 1'b0; pc0_write = 1'b0; ir_write = 1'b0; imem_valid = 1'b0;
      m_ir = word;
      chk("fetch.busy_cycles", 32'(busy_cycles), 32'(lat));
      chk("fetch.addr_hold", imem_addr, m_addr);
      chk_state("fetch");
      chk_fields("fetch");
    end
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};

    do_reset();
    chk("reset.req", 32'(imem_req), 32'h0);
    chk("reset.addr", imem_addr, 32'h0);
    chk_state("reset");

    // valid arrives three cycles after the request: four busy cycles
    fetch(32'h0050_0093, 4);
    chk("addi.imm", imm, 32'd5);
    chk("addi.rd", 32'(rd), 32'd1);

    // jal x1,+16 at 8
    set_pc(32'h8);
    fetch(32'h0100_00EF, 2);
    chk("jal.imm", imm, 32'd16);
    branch(1'b1);
    chk("jal.target", pc, 32'd24);

    // beq -8 at 20
    set_pc(32'd20);
    fetch(32'hFE00_0CE3, 1);
    chk("beq.imm", imm, 32'hFFFF_FFF8);
    branch(1'b0);
    chk("beq.nowrite", pc, 32'd24);
    branch(1'b1);
    chk("beq.target", pc, 32'd12);

    // reserved select holds PC
    pc_write = 1'b1; pc_s = 2'b11;
    cyc();
    pc_write = 1'b0;
    chk("pcs11.hold", pc, m_pc);

    // jalr clears bit0; the resulting misaligned fetch becomes a NOP
    set_pc(32'h0000_0103);
    chk("jalr.bit0", pc, 32'h0000_0102);
    ir_write = 1'b1;
    cyc();
    ir_write = 1'b0;
    m_ir = NOP; m_mis = 1'b1;
    chk("mis.req", 32'(imem_req), 32'h0);
    chk_state("mis");
    cyc();
    chk("mis.sticky", 32'(misalign), 32'h1);

    // reset during WAIT; a late valid is ignored
    do_reset();
    chk("reset2.misalign", 32'(misalign), 32'h0);
    pc_write = 1'b1; pc0_write = 1'b1; ir_write = 1'b1; pc_s = 2'b00;
    cyc();
    pc_write = 1'b0; pc0_write = 1'b0; ir_write = 1'b0;
    chk("rstwait.busy", 32'(busy), 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_valid = 1'b0;
    chk_state("rstwait");
    chk("rstwait.req", 32'(imem_req), 32'h0);

    // wrap at top of address space, junk PC_Write while busy
    set_pc(32'hFFFF_FFFC);
    fetch(32'h0000_0537, 3);
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.lui_imm", imm, 32'h0000_0000);

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] w;
      kind = $urandom_range(0, 5);
      case (kind)
        0: set_pc({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        1, 2: begin
          w = {$urandom} & 32'hFFFF_FF80;
          w[6:0] = ops[$urandom_range(0, 9)];
          fetch(w, $urandom_range(1, 5));
        end
        3: branch(1'($urandom_range(0, 1)));
        4: begin
          pc0_write = 1'b1;
          cyc();
          pc0_write = 1'b0;
          m_pc0 = m_pc;
          chk("rand.pc0", pc0, m_pc0);
        end
        default: begin
          pc_write = 1'b1; pc_s = 2'b00;
          cyc();
          pc_write = 1'b0;
          m_pc = m_pc + 32'd4;
          chk("rand.seq", pc, m_pc);
        end
      endcase
      chk_state("rand");
      $display("txn %0d kind=%0d pc=%h pc0=%h ir=%h", n, kind, pc, pc0, ir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
